// File: rtl/tx_pkg.sv
// Shared types for the serial frame transmitter.
// State enum, sel phase codes, frame-length helper. Optional: TX_PARITY_EN.
package tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [1:0] SEL_IDLE   = 2'd0;
  localparam logic [1:0] SEL_START  = 2'd1;
  localparam logic [1:0] SEL_DATA   = 2'd2;
  localparam logic [1:0] SEL_PARITY = 2'd3;

`ifdef TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int frame_len(
    input int data_w,
    input int stop_bits,
    input int baud_div,
    input int par
  );
    return (1 + data_w + par + stop_bits) * baud_div;
  endfunction

endpackage

// File: rtl/tx_baud_tick.sv
// Bit timer: counts 0..BAUD_DIV-1, flags the last cycle of each bit.
// Ports: clk, arst (sync, high), clear (hold at 0), bit_end.
module tx_baud_tick #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  output logic bit_end
);

  localparam int TW =
    (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TW-1:0] LAST =
    TW'(BAUD_DIV - 1);

  logic [TW-1:0] timer;

  assign bit_end = (timer == LAST);

  always_ff @(posedge clk) begin
    if (arst || clear) begin
      timer <= '0;
    end else if (bit_end) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Serial frame controller: start, DATA_W bits LSB first, parity, stop.
// Ports: clk, arst, in_valid/in_data/in_ready, tx, busy, sel, done.
// Optional parity bit enabled by TX_PARITY_EN.
module tx_frame_ctrl
  import tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic [1:0]        sel,
  output logic              done
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
    $error("DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 1) begin : g_bad_bd
    $error("BAUD_DIV must be >= 1");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_po
    $error("PARITY_ODD must be 0 or 1");
  end

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(DATA_W - 1);
  localparam logic LAST_STOP =
    1'(STOP_BITS - 1);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0]     idx;
  logic              stop_cnt;
  logic              bit_end;
  logic              tick_clear;
`ifdef TX_PARITY_EN
  logic              par;
`endif

  // No path from in_valid: safe for a source
  // that holds valid high.
  assign in_ready = (state == S_IDLE) & ~arst;

  // Timer is pinned at 0 in IDLE so START
  // always gets a full bit period.
  assign tick_clear = (state == S_IDLE);

  assign done = (state == S_STOP)
              & (stop_cnt == LAST_STOP)
              & bit_end;

  tx_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tick (
    .clk     (clk),
    .arst    (arst),
    .clear   (tick_clear),
    .bit_end (bit_end)
  );

  // Outputs are loaded with the values of the
  // state being entered, so they stay registered.
  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= S_IDLE;
      shift    <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      sel      <= SEL_IDLE;
`ifdef TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            shift <= in_data;
`ifdef TX_PARITY_EN
            par   <= (^in_data)
                   ^ 1'(PARITY_ODD);
`endif
            state <= S_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            sel   <= SEL_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            idx   <= '0;
            tx    <= shift[0];
            sel   <= SEL_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            idx   <= idx + IW'(1);
            if (idx == LAST_IDX) begin
`ifdef TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par;
              sel   <= SEL_PARITY;
`else
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
              sel      <= SEL_IDLE;
`endif
            end else begin
              tx <= shift[1];
            end
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            sel      <= SEL_IDLE;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          sel   <= SEL_IDLE;
        end
      endcase
    end
  end

endmodule
